// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: steps the matrix-multiply core over an N x K tiled job,
// producing per-run buffer offsets, start pulses and a per-run watchdog.
module mm_tile_sequencer #(
  parameter int W_AW    = 8,
  parameter int I_AW    = 8,
  parameter int O_AW    = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_sync_i,
  input  logic             go_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] k_tiles_i,
  input  logic [CNT_W-1:0] n_tiles_i,
  input  logic [W_AW-1:0]  w_base_i,
  input  logic [W_AW-1:0]  w_step_i,
  input  logic [I_AW-1:0]  i_base_i,
  input  logic [I_AW-1:0]  i_step_i,
  input  logic [O_AW-1:0]  o_base_i,
  input  logic [O_AW-1:0]  o_step_i,
  input  logic             core_done_i,
  output logic             start_o,
  output logic [W_AW-1:0]  w_offset_o,
  output logic [I_AW-1:0]  i_offset_o,
  output logic [O_AW-1:0]  o_offset_o,
  output logic [O_AW-1:0]  psum_offset_o,
  output logic             accum_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_START, ST_WAIT, ST_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] k_tiles_q, n_tiles_q, k_idx, n_idx;
  logic [W_AW-1:0]  w_step_q, w_off;
  logic [I_AW-1:0]  i_base_q, i_step_q, i_off;
  logic [O_AW-1:0]  o_step_q, o_off;
  logic             accum_en, error_q;
  logic [WD_W-1:0]  wd_cnt;
  logic             capture, advance, wd_expire;
  logic             last_k, last_n, wd_hit;

  // Counts are nonzero whenever a run is in flight, so count-1 never underflows.
  assign last_k = (k_idx == k_tiles_q - CNT_W'(1));
  assign last_n = (n_idx == n_tiles_q - CNT_W'(1));
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_W'(WD_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    advance    = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_i) begin
          capture    = 1'b1;
          state_next = (k_tiles_i == '0 || n_tiles_i == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done_i) begin
          advance    = 1'b1;
          state_next = (last_k && last_n) ? ST_DONE : ST_SETUP;
        end else if (wd_hit) begin
          wd_expire  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Abort outranks both core completion and the watchdog.
    if (abort_i && state != ST_IDLE) begin
      state_next = ST_IDLE;
      advance    = 1'b0;
      wd_expire  = 1'b0;
    end
    start_o = (state == ST_START) && !abort_i;
    done_o  = (state == ST_DONE) && !abort_i;
    busy_o  = (state != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      k_tiles_q <= '0;
      n_tiles_q <= '0;
      w_step_q  <= '0;
      i_base_q  <= '0;
      i_step_q  <= '0;
      o_step_q  <= '0;
      k_idx     <= '0;
      n_idx     <= '0;
      w_off     <= '0;
      i_off     <= '0;
      o_off     <= '0;
      accum_en  <= 1'b0;
      error_q   <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      if (capture) begin
        k_tiles_q <= k_tiles_i;
        n_tiles_q <= n_tiles_i;
        w_step_q  <= w_step_i;
        i_base_q  <= i_base_i;
        i_step_q  <= i_step_i;
        o_step_q  <= o_step_i;
        k_idx     <= '0;
        n_idx     <= '0;
        w_off     <= w_base_i;
        i_off     <= i_base_i;
        o_off     <= o_base_i;
        accum_en  <= 1'b0;
        error_q   <= 1'b0;
      end
      // On the final run only the weight offset moves; k/n stay put.
      if (advance) begin
        w_off <= w_off + w_step_q;
        if (!last_k) begin
          k_idx    <= k_idx + CNT_W'(1);
          i_off    <= i_off + i_step_q;
          accum_en <= 1'b1;
        end else if (!last_n) begin
          k_idx    <= '0;
          n_idx    <= n_idx + CNT_W'(1);
          i_off    <= i_base_q;
          o_off    <= o_off + o_step_q;
          accum_en <= 1'b0;
        end
      end
      if (wd_expire) error_q <= 1'b1;
      if (state == ST_START)                    wd_cnt <= '0;
      else if (state == ST_WAIT && TIMEOUT != 0) wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign w_offset_o    = w_off;
  assign i_offset_o    = i_off;
  assign o_offset_o    = o_off;
  assign psum_offset_o = o_off;
  assign accum_en_o    = accum_en;
  assign error_o       = error_q;

endmodule
